pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised fetch-stage program counter. Successor to the fixed 32-bit reset/load PC.
//  Selects next PC from trap vector, redirect, return-address prediction or sequential PC+IALIGN.
//  Drives the instruction-memory request through a valid/ready handshake.
//  Sits between the hazard/branch resolution logic and the IF/ID pipeline register.
// PARAMETERS
//  XLEN       32       PC width in bits
//  RESET_VEC  'h0      PC value after reset
//  TRAP_VEC   'h100    PC loaded on trap_valid_i
//  IALIGN     4        instruction alignment / sequential step; legal values 2 or 4 only
//  RAS_DEPTH  4        return-address-stack entries; power of two, >=2 (used only with PC_RAS_EN)
// PORTS
//  clk               in   1     clock, rising edge
//  rst_n             in   1     asynchronous reset, active low
//  stall_i           in   1     hold PC (hazard unit)
//  fetch_ready_i     in   1     IMEM accepts request
//  fetch_valid_o     out  1     pc_o is a valid fetch request
//  pc_o              out  XLEN  current fetch PC
//  pc_plus_o         out  XLEN  pc_o + IALIGN (comb, modulo 2^XLEN)
//  redirect_valid_i  in   1     branch/jump resolved taken
//  redirect_pc_i     in   XLEN  redirect target
//  trap_valid_i      in   1     exception/interrupt
//  misalign_o        out  1     registered 1-cycle pulse: last redirect target had low bits set
//  ras_push_i        in   1     fetched instr is a call; push pc_plus_o
//  ras_pop_i         in   1     fetched instr is a return; predict from RAS
//  ras_empty_o       out  1     RAS holds no entries
// BEHAVIOUR
//  Reset (async assert, sync release): pc_o=RESET_VEC, fetch_valid_o=0, misalign_o=0, RAS count=0.
//  First edge after release: fetch_valid_o=1; pc_o stays RESET_VEC.
//  accept = fetch_valid_o & fetch_ready_i & ~stall_i.
//  Next-PC priority, registered at posedge:
//    trap_valid_i > redirect_valid_i > (accept & ras_pop_i & ~ras_empty_o) > accept > hold.
//  Trap and redirect ignore stall_i and fetch_ready_i; they take effect next cycle. No latching of
//  pulses. A redirect drops any pending unaccepted request.
//  Redirect target: low log2(IALIGN) bits are forced to 0; misalign_o=1 for the next cycle if any were set.
//  Sequential: pc_o <= pc_o + IALIGN; wraps from 2^XLEN-IALIGN to 0 with no flag.
//  Trap: pc_o <= TRAP_VEC; RAS count cleared in the same edge.
//  RAS operations act only on accept and never during trap/redirect cycles:
//    push only: write top.
//    pop only:  next PC = top, then discard top.
//    push+pop:  next PC = old top, top replaced by pc_plus_o; count unchanged.
//    push when full: circular overwrite of oldest; count saturates at RAS_DEPTH.
//    pop when empty: ignored, sequential PC used, count stays 0.
//  Latency: accept -> new pc_o is 1 cycle. No combinational path from ras_*_i to pc_o.
// CONFIGURATION
//  PC_RAS_EN defined: RAS instantiated as above.
//  PC_RAS_EN undefined: no RAS storage; ras_push_i/ras_pop_i ignored; ras_empty_o tied 1;
//  next-PC priority reduces to trap > redirect > accept > hold.
// STRUCTURE
//  Shared package pc_pkg:
//    next-PC select enum {SEL_HOLD, SEL_SEQ, SEL_RAS, SEL_REDIR, SEL_TRAP};
//    IALIGN legality check; default vector constants.
//  Sub-module pc_ras: circular stack with ptr, count, push/pop/clear, top, empty.
//  Compiled only under PC_RAS_EN.
//  Top level holds the select mux, PC register, valid and misalign flops.
// TESTING
//  1 Reset release, ready=1, no stall, 4 cycles
//    -> pc_o 0x0, 0x0 (valid rises), 0x4, 0x8.
//  2 stall_i=1 at pc 0x8, redirect 0x40 in same cycle
//    -> pc_o=0x40 next cycle despite stall.
//  3 Redirect to 0x43 with IALIGN=4 -> pc_o=0x40, misalign_o=1 for one cycle.
//    Redirect 0x42 with IALIGN=2 -> pc_o=0x42, no flag.
//  4 trap_valid_i together with redirect 0x80 -> pc_o=0x100, RAS empty.
//    Assert rst_n low mid-stream -> pc_o=0 immediately, without waiting for a clock edge.
//  5 PC_RAS_EN: push at 0x10, 0x20, 0x30, 0x40, 0x50 with depth 4; then 5 pops
//    -> pc_o 0x54, 0x44, 0x34, 0x24, then sequential; ras_empty_o=1 after the 4th pop.
//  6 pc_o=32'hFFFFFFFC, accept -> pc_o=0. fetch_ready_i=0 for 3 cycles -> pc_o held, fetch_valid_o stays 1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_SEQ   = 3'd1,
    SEL_RAS   = 3'd2,
    SEL_REDIR = 3'd3,
    SEL_TRAP  = 3'd4
  } pc_sel_e;

  localparam logic [63:0] DEF_RESET_VEC = 64'h0;
  localparam logic [63:0] DEF_TRAP_VEC  = 64'h100;

  function automatic logic ialign_legal(input int unsigned ialign);
    return (ialign == 32'd2) || (ialign == 32'd4);
  endfunction

endpackage

// File: rtl/pc_gen_unit_ras.sv
// Circular return-address stack; built only when PC_RAS_EN is defined.
`ifdef PC_RAS_EN
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] top_idx_s;
  logic             pop_s;

  // ptr_r is the next free slot; the top lives one below it, wrapping.
  assign top_idx_s = ptr_r - PTR_W'(1);
  assign top       = mem_r[top_idx_s];
  assign empty     = (count_r == CNT_W'(0));
  assign pop_s     = pop & ~empty;

  // Stack pointer, occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= '0;
      count_r <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
    end else if (clear) begin
      ptr_r   <= '0;
      count_r <= '0;
    end else if (push && pop_s) begin
      mem_r[top_idx_s] <= push_data;
    end else if (push) begin
      mem_r[ptr_r] <= push_data;
      ptr_r        <= ptr_r + PTR_W'(1);
      if (count_r != CNT_W'(DEPTH)) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end else if (pop_s) begin
      ptr_r   <= top_idx_s;
      count_r <= count_r - CNT_W'(1);
    end else begin
      ptr_r   <= ptr_r;
      count_r <= count_r;
    end
  end

endmodule
`endif

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: trap > redirect > RAS prediction > sequential > hold.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int unsigned     IALIGN    = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  output logic            misalign_o,
  input  logic            ras_push_i,
  input  logic            ras_pop_i,
  output logic            ras_empty_o
);

  // An illegal IALIGN falls back to the 4-byte step.
  localparam int unsigned     STEP     = ialign_legal(IALIGN) ? IALIGN : 32'd4;
  localparam logic [XLEN-1:0] STEP_V   = XLEN'(STEP);
  localparam logic [XLEN-1:0] LOW_MASK = STEP_V - XLEN'(1);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] ras_top_s;
  logic            valid_r;
  logic            misalign_r;
  logic            accept_s;
  logic            ras_hit_s;
  pc_sel_e         sel_s;

  assign accept_s  = valid_r & fetch_ready_i & ~stall_i;
  assign pc_plus_o = pc_r + STEP_V;

`ifdef PC_RAS_EN
  logic ras_push_s;
  logic ras_pop_s;
  logic ras_empty_s;

  assign ras_push_s = accept_s & ras_push_i & ~trap_valid_i & ~redirect_valid_i;
  assign ras_pop_s  = accept_s & ras_pop_i  & ~trap_valid_i & ~redirect_valid_i;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (trap_valid_i),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (pc_plus_o),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  assign ras_hit_s   = accept_s & ras_pop_i & ~ras_empty_s;
  assign ras_empty_o = ras_empty_s;
`else
  logic unused_ras_s;
  assign unused_ras_s = ^{ras_push_i, ras_pop_i, RAS_DEPTH[0]};
  assign ras_hit_s    = 1'b0;
  assign ras_top_s    = '0;
  assign ras_empty_o  = 1'b1;
`endif

  // Next-PC source priority.
  always_comb begin
    sel_s = SEL_HOLD;
    if (trap_valid_i) begin
      sel_s = SEL_TRAP;
    end else if (redirect_valid_i) begin
      sel_s = SEL_REDIR;
    end else if (ras_hit_s) begin
      sel_s = SEL_RAS;
    end else if (accept_s) begin
      sel_s = SEL_SEQ;
    end else begin
      sel_s = SEL_HOLD;
    end
  end

  // Next-PC mux; redirect targets are forced onto the instruction grid.
  always_comb begin
    pc_next_s = pc_r;
    case (sel_s)
      SEL_TRAP:  pc_next_s = TRAP_VEC;
      SEL_REDIR: pc_next_s = redirect_pc_i & ~LOW_MASK;
      SEL_RAS:   pc_next_s = ras_top_s;
      SEL_SEQ:   pc_next_s = pc_plus_o;
      SEL_HOLD:  pc_next_s = pc_r;
      default:   pc_next_s = pc_r;
    endcase
  end

  // PC, request-valid and misalignment-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_VEC;
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      valid_r    <= 1'b1;
      misalign_r <= redirect_valid_i & ~trap_valid_i & ((redirect_pc_i & LOW_MASK) != '0);
    end
  end

  assign pc_o          = pc_r;
  assign fetch_valid_o = valid_r;
  assign misalign_o    = misalign_r;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit (IALIGN=4 and IALIGN=2 instances on shared inputs).
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, ready, rvalid, trap, push, pop;
  logic [31:0] rpc;

  logic        v4, mis4, emp4, v2, mis2, emp2;
  logic [31:0] pc4, pp4, pc2, pp2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(.IALIGN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .fetch_ready_i(ready),
    .fetch_valid_o(v4), .pc_o(pc4), .pc_plus_o(pp4),
    .redirect_valid_i(rvalid), .redirect_pc_i(rpc), .trap_valid_i(trap),
    .misalign_o(mis4), .ras_push_i(push), .ras_pop_i(pop), .ras_empty_o(emp4)
  );

  pc_gen_unit #(.IALIGN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .fetch_ready_i(ready),
    .fetch_valid_o(v2), .pc_o(pc2), .pc_plus_o(pp2),
    .redirect_valid_i(rvalid), .redirect_pc_i(rpc), .trap_valid_i(trap),
    .misalign_o(mis2), .ras_push_i(push), .ras_pop_i(pop), .ras_empty_o(emp2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; ready = 1'b1; rvalid = 1'b0;
    trap = 1'b0; push = 1'b0; pop = 1'b0; rpc = 32'h0;

    // Reset state
    #1;
    check("rst_pc", pc4, 32'h0);
    check("rst_valid", {31'd0, v4}, 32'd0);
    check("rst_misalign", {31'd0, mis4}, 32'd0);
    check("rst_ras_empty", {31'd0, emp4}, 32'd1);
    #11 rst_n = 1'b1;

    // 1: release, valid rises with pc held, then sequential
    tick();
    check("t1_valid", {31'd0, v4}, 32'd1);
    check("t1_pc0", pc4, 32'h0);
    tick();
    check("t1_pc4", pc4, 32'h4);
    check("t1_pc4_ia2", pc2, 32'h2);
    tick();
    check("t1_pc8", pc4, 32'h8);
    check("t1_pcplus", pp4, 32'hC);

    // 2: redirect overrides stall
    stall = 1'b1; rvalid = 1'b1; rpc = 32'h40;
    tick();
    check("t2_redir_stall", pc4, 32'h40);
    check("t2_no_misalign", {31'd0, mis4}, 32'd0);
    rvalid = 1'b0;
    tick();
    check("t2_hold", pc4, 32'h40);
    stall = 1'b0;

    // 3: misaligned redirect targets
    rvalid = 1'b1; rpc = 32'h43;
    tick();
    check("t3_ia4_pc", pc4, 32'h40);
    check("t3_ia4_mis", {31'd0, mis4}, 32'd1);
    check("t3_ia2_pc43", pc2, 32'h42);
    rpc = 32'h42;
    tick();
    check("t3_ia2_pc42", pc2, 32'h42);
    check("t3_ia2_nomis", {31'd0, mis2}, 32'd0);
    check("t3_ia4_mis42", {31'd0, mis4}, 32'd1);
    rvalid = 1'b0;
    tick();
    check("t3_mis_pulse_end", {31'd0, mis4}, 32'd0);
    check("t3_seq", pc4, 32'h44);

    // 4: trap beats redirect and clears the RAS; async reset mid-stream
    push = 1'b1;
    tick();
    check("t4_push_seq", pc4, 32'h48);
`ifdef PC_RAS_EN
    check("t4_ras_nonempty", {31'd0, emp4}, 32'd0);
`else
    check("t4_ras_tied", {31'd0, emp4}, 32'd1);
`endif
    trap = 1'b1; rvalid = 1'b1; rpc = 32'h80;
    tick();
    check("t4_trap_pc", pc4, 32'h100);
    check("t4_trap_ras_empty", {31'd0, emp4}, 32'd1);
    trap = 1'b0; rvalid = 1'b0; push = 1'b0;
    tick();
    check("t4_after_trap", pc4, 32'h104);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_rst_pc", pc4, 32'h0);
    check("t4_async_rst_valid", {31'd0, v4}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("t4_rerelease_pc", pc4, 32'h0);
    tick();
    check("t4_rerelease_seq", pc4, 32'h4);

`ifdef PC_RAS_EN
    // 5: five calls into a 4-deep stack, then five returns
    rvalid = 1'b1; rpc = 32'h10;
    tick();
    rvalid = 1'b0;
    check("t5_start", pc4, 32'h10);
    for (int k = 32'h10; k <= 32'h50; k += 4) begin
      push = ((k % 16) == 0);
      tick();
      check("t5_call_seq", pc4, 32'(k + 4));
    end
    push = 1'b0; pop = 1'b1;
    tick();
    check("t5_pop1", pc4, 32'h54);
    tick();
    check("t5_pop2", pc4, 32'h44);
    tick();
    check("t5_pop3", pc4, 32'h34);
    check("t5_not_empty", {31'd0, emp4}, 32'd0);
    tick();
    check("t5_pop4", pc4, 32'h24);
    check("t5_empty", {31'd0, emp4}, 32'd1);
    tick();
    check("t5_pop_empty_seq", pc4, 32'h28);
    check("t5_still_empty", {31'd0, emp4}, 32'd1);
    pop = 1'b0;
`else
    // 5: RAS absent, pops are ignored
    pop = 1'b1;
    tick();
    check("t5_pop_ignored", pc4, 32'h8);
    check("t5_empty_tied", {31'd0, emp4}, 32'd1);
    pop = 1'b0;
`endif

    // 6: wrap and fetch back-pressure
    rvalid = 1'b1; rpc = 32'hFFFF_FFFC;
    tick();
    rvalid = 1'b0;
    check("t6_top_pc", pc4, 32'hFFFF_FFFC);
    check("t6_pcplus_wrap", pp4, 32'h0);
    tick();
    check("t6_wrap", pc4, 32'h0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_hold_pc", pc4, 32'h0);
      check("t6_hold_valid", {31'd0, v4}, 32'd1);
    end
    ready = 1'b1;
    tick();
    check("t6_resume", pc4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
